// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - four-source writeback arbiter for the single register-file write port
module wb_port_arbiter #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 5,
  parameter int PRIO_MODE = 0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          req_valid,
  input  logic [4*ADDR_W-1:0] req_addr,
  input  logic [4*DATA_W-1:0] req_data,
  output logic [3:0]          req_ready,
  input  logic                stall,
  output logic                rf_we,
  output logic [ADDR_W-1:0]   rf_waddr,
  output logic [DATA_W-1:0]   rf_wdata,
  output logic [1:0]          wb_sel,
  output logic                conflict
);

  logic [1:0]        rr_ptr;
  logic [1:0]        win;
  logic              found;
  logic              take;
  logic [1:0]        idx;
  logic [1:0]        base;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_data;
  logic              multi;

  // Scan starts at rr_ptr in round-robin mode, at source 0 in fixed mode.
  assign base = (PRIO_MODE != 0) ? 2'd0 : rr_ptr;

  always_comb begin
    win   = 2'd0;
    found = 1'b0;
    idx   = 2'd0;
    for (int k = 0; k < 4; k++) begin
      idx = base + 2'(k);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
  end

  assign take      = found && !stall && rst_n;
  assign req_ready = take ? (4'b0001 << win) : 4'b0000;
  assign win_addr  = req_addr[win*ADDR_W +: ADDR_W];
  assign win_data  = req_data[win*DATA_W +: DATA_W];
  assign multi     = (req_valid & (req_valid - 4'd1)) != 4'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we    <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
      wb_sel   <= 2'b00;
      conflict <= 1'b0;
      rr_ptr   <= 2'd0;
    end else begin
      conflict <= multi && !stall;
      if (take) begin
        // Writes to $0 are acknowledged to the source but never reach the file.
        rf_we    <= (win_addr != '0);
        rf_waddr <= win_addr;
        rf_wdata <= win_data;
        wb_sel   <= win;
        rr_ptr   <= win + 2'd1;
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

endmodule
